// File: rtl/menuscreen_pkg.sv
// Shared types and constants for the menu-screen fade controller.
package menuscreen_pkg;

  typedef enum logic [1:0] {BLACK, FADE_IN, SHOWN, FADE_OUT} fade_state_t;

  localparam int unsigned FADE_LEVEL_W = 5;
  localparam int unsigned FADE_MAX     = 16;

endpackage

// File: rtl/fade_scaler.sv
// Registered three-channel brightness scaler: out = en ? (c * level) >> 4 : 0.
module fade_scaler
  import menuscreen_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    en,
  input  logic [FADE_LEVEL_W-1:0] level,
  input  logic [3:0]              red_in,
  input  logic [3:0]              green_in,
  input  logic [3:0]              blue_in,
  output logic [3:0]              red_out,
  output logic [3:0]              green_out,
  output logic [3:0]              blue_out
);

  // Level 16 is the identity scale, so the 9-bit product never needs bit 8.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [FADE_LEVEL_W-1:0] lvl);
    logic [8:0] prod;
    prod = {5'b0, c} * {4'b0, lvl};
    return prod[7:4];
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (en) begin
      red_out   <= scale(red_in, level);
      green_out <= scale(green_in, level);
      blue_out  <= scale(blue_in, level);
    end else begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end
  end

endmodule

// File: rtl/menuscreen_fade_ctrl.sv
// Menu-screen fade sequencer: timed brightness ramp plus a two-stage palette/scale pixel pipe.
module menuscreen_fade_ctrl
  import menuscreen_pkg::*;
#(
  parameter int unsigned STEP_FRAMES = 4,
  parameter int unsigned MAX_LEVEL   = 16
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start_in,
  input  logic                    start_out,
  input  logic                    frame_tick,
  input  logic [7:0]              index_in,
  input  logic                    display_en,
  output logic [7:0]              pal_index,
  input  logic [3:0]              pal_red,
  input  logic [3:0]              pal_green,
  input  logic [3:0]              pal_blue,
  output logic [3:0]              vga_red,
  output logic [3:0]              vga_green,
  output logic [3:0]              vga_blue,
  output logic [FADE_LEVEL_W-1:0] level,
  output logic                    busy,
  output logic                    done
);

  localparam logic [7:0]              CntLast = 8'(STEP_FRAMES - 1);
  localparam logic [FADE_LEVEL_W-1:0] LvlMax  = FADE_LEVEL_W'(MAX_LEVEL);

  fade_state_t state;
  logic [7:0]  frame_cnt;
  logic        en_d1;
  logic        accept_in;
  logic        accept_out;

  assign busy       = (state == FADE_IN) || (state == FADE_OUT);
  // The legal source states of the two commands are disjoint, so start_out priority is trivial.
  assign accept_out = start_out && ((state == SHOWN) || (state == FADE_IN));
  assign accept_in  = start_in && ((state == BLACK) || (state == FADE_OUT)) && !accept_out;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pal_index <= '0;
      en_d1     <= 1'b0;
    end else begin
      pal_index <= index_in;
      en_d1     <= display_en;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= BLACK;
      level     <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_out) begin
        state     <= FADE_OUT;
        frame_cnt <= '0;
      end else if (accept_in) begin
        state     <= FADE_IN;
        frame_cnt <= '0;
      end else if (busy && frame_tick) begin
        if (frame_cnt == CntLast) begin
          frame_cnt <= '0;
          // A reversal can start a fade already at its end level; the clamp finishes it.
          if (state == FADE_IN) begin
            if (level >= LvlMax - 5'd1) begin
              level <= LvlMax;
              state <= SHOWN;
              done  <= 1'b1;
            end else begin
              level <= level + 5'd1;
            end
          end else begin
            if (level <= 5'd1) begin
              level <= '0;
              state <= BLACK;
              done  <= 1'b1;
            end else begin
              level <= level - 5'd1;
            end
          end
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  fade_scaler u_scaler (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .en        (en_d1),
    .level     (level),
    .red_in    (pal_red),
    .green_in  (pal_green),
    .blue_in   (pal_blue),
    .red_out   (vga_red),
    .green_out (vga_green),
    .blue_out  (vga_blue)
  );

endmodule
